seq_detect_moore_param: RTL and testbench

- Parametrised Moore sequence detector. Next generation of the team's fixed 3-bit/4-step detector.
- Matches a runtime-programmable pattern of SEQ_LEN symbols, each SYM_W bits wide, on a qualified symbol stream.
- Adds programmable overlap restart, fresh/chained hit classification, a saturating hit counter and a synchronous clear.
- Sits between the input symbol source and the downstream status/LED logic.

---
 rtl/seq_detect_moore_param.sv | 103 ++++++++++
 tb/tb_seq_detect_moore_param.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_moore_param.sv
// Parametrised Moore sequence detector: matches a programmable SEQ_LEN-symbol pattern
// on a qualified stream, with overlap restart, chained-hit flag and saturating hit counter.
module seq_detect_moore_param #(
  parameter int SYM_W   = 3,
  parameter int SEQ_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [SYM_W-1:0]         sym,
  input  logic [SEQ_LEN*SYM_W-1:0] pattern,
  input  logic [3:0]               ovl_len,
  input  logic                     clear,
  output logic [1:0]               done,
  output logic [CNT_W-1:0]         match_cnt,
  output logic [3:0]               progress
);

  typedef enum logic [1:0] {IDLE, MATCH, HIT} state_t;

  state_t           state_q, state_d;
  logic [3:0]       prog_q, prog_d;
  logic             chain_q, chain_d;
  logic [1:0]       done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [SYM_W-1:0] pat_sym [16];
  logic [3:0]       ovl_eff;
  logic [3:0]       cur_idx;
  logic             advance;
  logic             restart;

  // Unpack the pattern into a 16-entry table so a 4-bit index always fits.
  for (genvar gi = 0; gi < 16; gi++) begin : g_pat
    if (gi < SEQ_LEN) begin : g_used
      assign pat_sym[gi] = pattern[gi*SYM_W +: SYM_W];
    end else begin : g_pad
      assign pat_sym[gi] = '0;
    end
  end

  assign ovl_eff = (ovl_len >= 4'(SEQ_LEN)) ? 4'd0 : ovl_len;
  assign cur_idx = (state_q == HIT) ? ovl_eff : prog_q;
  assign advance = (sym == pat_sym[cur_idx]);
  assign restart = (sym == pat_sym[0]);

  always_comb begin
    state_d = state_q;
    prog_d  = prog_q;
    chain_d = chain_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = IDLE;
      prog_d  = 4'd0;
      chain_d = 1'b0;
      done_d  = 2'b00;
      cnt_d   = '0;
    end else if (en) begin
      if (advance) begin
        prog_d = cur_idx + 4'd1;
        // Leaving HIT by resuming mid-pattern marks the next hit as chained.
        if (state_q == HIT) chain_d = (cur_idx != 4'd0);
      end else if (restart) begin
        prog_d  = 4'd1;
        chain_d = 1'b0;
      end else begin
        prog_d  = 4'd0;
        chain_d = 1'b0;
      end
      if (prog_d == 4'(SEQ_LEN)) begin
        state_d = HIT;
        done_d  = {1'b1, chain_d};
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        state_d = (prog_d == 4'd0) ? IDLE : MATCH;
        done_d  = 2'b00;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      prog_q  <= 4'd0;
      chain_q <= 1'b0;
      done_q  <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prog_q  <= prog_d;
      chain_q <= chain_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign done      = done_q;
  assign match_cnt = cnt_q;
  assign progress  = prog_q;

endmodule

// File: tb/tb_seq_detect_moore_param.sv
// Bench for seq_detect_moore_param: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against an integer reference model.
module tb_seq_detect_moore_param;
  localparam int SW = 3;
  localparam int SL = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en = 1'b0;
  logic           clear = 1'b0;
  logic [SW-1:0]  sym = '0;
  logic [SL*SW-1:0] pattern = {3'b110, 3'b000, 3'b110, 3'b000};
  logic [3:0]     ovl_len = 4'd0;

  logic [1:0] done, done_s;
  logic [7:0] cnt;
  logic [1:0] cnt_s;
  logic [3:0] prog, prog_s;

  int vectors = 0;
  int errors  = 0;

  seq_detect_moore_param #(.SYM_W(SW), .SEQ_LEN(SL), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .sym(sym), .pattern(pattern), .ovl_len(ovl_len),
    .clear(clear), .done(done), .match_cnt(cnt), .progress(prog)
  );

  seq_detect_moore_param #(.SYM_W(SW), .SEQ_LEN(SL), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .sym(sym), .pattern(pattern), .ovl_len(ovl_len),
    .clear(clear), .done(done_s), .match_cnt(cnt_s), .progress(prog_s)
  );

  always #5 clk = ~clk;

  // Reference model: matched count as a plain integer, hit count unbounded.
  int       m_prog = 0;
  int       m_cnt = 0;
  bit       m_chain = 1'b0;
  bit [1:0] m_done = 2'b00;

  function automatic int pat_at(int k);
    logic [SL*SW-1:0] p;
    p = pattern >> (k * SW);
    return int'(p[SW-1:0]);
  endfunction

  always @(posedge clk or negedge rst) begin
    int lim, idx;
    if (!rst || clear) begin
      m_prog = 0; m_cnt = 0; m_chain = 1'b0; m_done = 2'b00;
    end else if (en) begin
      lim = (int'(ovl_len) >= SL) ? 0 : int'(ovl_len);
      idx = (m_prog == SL) ? lim : m_prog;
      if (int'(sym) == pat_at(idx)) begin
        if (m_prog == SL) m_chain = (lim > 0);
        m_prog = idx + 1;
      end else if (int'(sym) == pat_at(0)) begin
        m_prog = 1; m_chain = 1'b0;
      end else begin
        m_prog = 0; m_chain = 1'b0;
      end
      if (m_prog == SL) begin
        m_cnt++;
        m_done = {1'b1, m_chain};
      end else begin
        m_done = 2'b00;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_prog", int'(prog), m_prog);
    chk("model_done", int'(done), int'(m_done));
    chk("model_cnt", int'(cnt), (m_cnt > 255) ? 255 : m_cnt);
    chk("model_prog_sat", int'(prog_s), m_prog);
    chk("model_done_sat", int'(done_s), int'(m_done));
    chk("model_cnt_sat", int'(cnt_s), (m_cnt > 3) ? 3 : m_cnt);
  end

  task automatic apply(input bit e, input logic [SW-1:0] s);
    en = e;
    sym = s;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic feed_hit();
    apply(1'b1, 3'b000); apply(1'b1, 3'b110); apply(1'b1, 3'b000); apply(1'b1, 3'b110);
  endtask

  initial begin
    int exp_prog [5];
    int exp_sat [5];
    exp_prog = '{1, 1, 2, 3, 0};
    exp_sat  = '{1, 2, 3, 3, 3};

    @(negedge clk); @(negedge clk);
    chk("reset_prog", int'(prog), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_cnt", int'(cnt), 0);
    rst = 1'b1;

    // Basic hit
    apply(1'b1, 3'b000); chk("t1_p1", int'(prog), 1);
    apply(1'b1, 3'b110); chk("t1_p2", int'(prog), 2);
    apply(1'b1, 3'b000); chk("t1_p3", int'(prog), 3);
    apply(1'b1, 3'b110); chk("t1_p4", int'(prog), 4);
    chk("t1_done", int'(done), 2);
    chk("t1_cnt", int'(cnt), 1);

    // Overlap restart, then non-overlapping
    ovl_len = 4'd2;
    apply(1'b1, 3'b000); chk("t2_p3", int'(prog), 3);
    apply(1'b1, 3'b110); chk("t2_p4", int'(prog), 4);
    chk("t2_done", int'(done), 3);
    chk("t2_cnt", int'(cnt), 2);
    ovl_len = 4'd0;
    apply(1'b1, 3'b000); apply(1'b1, 3'b110);
    chk("t2b_prog", int'(prog), 2);
    chk("t2b_done", int'(done), 0);

    // Fallback, then en gaps
    clear = 1'b1; apply(1'b1, 3'b000); clear = 1'b0;
    chk("t3_clear_cnt", int'(cnt), 0);
    begin
      logic [SW-1:0] st [5];
      st = '{3'b000, 3'b000, 3'b110, 3'b000, 3'b111};
      for (int i = 0; i < 5; i++) begin
        apply(1'b1, st[i]);
        chk($sformatf("t3_fb_prog%0d", i), int'(prog), exp_prog[i]);
        chk($sformatf("t3_fb_done%0d", i), int'(done), 0);
      end
    end
    apply(1'b1, 3'b000); apply(1'b0, 3'b111); chk("t3_gap_p1", int'(prog), 1);
    apply(1'b1, 3'b110); apply(1'b0, 3'b000); chk("t3_gap_p2", int'(prog), 2);
    apply(1'b1, 3'b000); apply(1'b0, 3'b110); chk("t3_gap_p3", int'(prog), 3);
    apply(1'b1, 3'b110); chk("t3_gap_done", int'(done), 2);
    apply(1'b0, 3'b101); chk("t3_hold_done", int'(done), 2);
    chk("t3_hold_prog", int'(prog), 4);

    // Saturation on the narrow counter
    clear = 1'b1; apply(1'b1, 3'b000); clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      feed_hit();
      chk($sformatf("t4_sat%0d", i), int'(cnt_s), exp_sat[i]);
      chk($sformatf("t4_cnt%0d", i), int'(cnt), i + 1);
    end

    // Synchronous clear while in HIT, sym on that edge ignored
    clear = 1'b1; apply(1'b1, 3'b000); clear = 1'b0;
    chk("t5_prog", int'(prog), 0);
    chk("t5_done", int'(done), 0);
    chk("t5_cnt", int'(cnt), 0);

    // Asynchronous reset mid-period
    feed_hit();
    apply(1'b1, 3'b000); apply(1'b1, 3'b110); apply(1'b1, 3'b000);
    chk("t6_pre_prog", int'(prog), 3);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_prog", int'(prog), 0);
    chk("t6_rst_done", int'(done), 0);
    chk("t6_rst_cnt", int'(cnt), 0);
    @(negedge clk);
    rst = 1'b1;
    feed_hit();
    chk("t6_done", int'(done), 2);
    chk("t6_cnt", int'(cnt), 1);

    // Randomized traffic on a small alphabet so hits are frequent
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 199) == 0)
        for (int k = 0; k < SL; k++) pattern[k*SW +: SW] = 3'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) ovl_len = 4'($urandom_range(0, 15));
      clear = ($urandom_range(0, 99) == 0);
      en = ($urandom_range(0, 4) != 0);
      sym = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
      if ($urandom_range(0, 299) == 0) begin
        #($urandom_range(1, 4)) rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    en = 1'b0;
    clear = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
